// File: rtl/boot_region_loader.sv
// boot_region_loader: boot-time copy engine that walks a table of flash->SD-RAM regions and copies each one.
//  Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   START           one-cycle pulse, accepted only when idle
//   BUSY, DONE      copy in progress / one-cycle completion pulse (also on timeout abort)
//   ERROR           sticky flash-timeout flag, cleared by an accepted START
//   REGION_IDX      table entry currently being copied (0 when idle)
//   FLASH_*         byte read request/ack handshake towards the flash reader
//   RAM_*           16-bit word write request/ack handshake towards SD-RAM
module boot_region_loader #(
    parameter int                          NUM_REGIONS    = 3,
    parameter logic [NUM_REGIONS*24-1:0]   REGION_FLASH   = {24'h1F_0000, 24'h12_0000, 24'h10_0000},
    parameter logic [NUM_REGIONS*24-1:0]   REGION_RAM     = {24'h77_E000, 24'h72_0000, 24'h70_0000},
    parameter logic [NUM_REGIONS*24-1:0]   REGION_SIZE    = {24'h00_2000, 24'h00_4000, 24'h00_4000},
    parameter logic [NUM_REGIONS-1:0]      REGION_EN      = '1,
    parameter int                          TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [2:0]  REGION_IDX,
    output logic        FLASH_REQ,
    output logic [23:0] FLASH_ADDR,
    input  logic        FLASH_ACK,
    input  logic [7:0]  FLASH_DATA,
    output logic        RAM_WE,
    output logic [23:0] RAM_ADDR,
    output logic [15:0] RAM_DATA,
    output logic [1:0]  RAM_BE,
    input  logic        RAM_ACK
);
    // Tables padded to 8 entries so a 3-bit index always selects a legal slice.
    localparam logic [8*24-1:0] FL = (8*24)'(REGION_FLASH);
    localparam logic [8*24-1:0] RM = (8*24)'(REGION_RAM);
    localparam logic [8*24-1:0] SZ = (8*24)'(REGION_SIZE);
    localparam logic [7:0]      EN = 8'(REGION_EN);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_RD, S_PACK, S_DRAIN, S_FIN} state_t;

    state_t      state;
    logic [3:0]  sel;
    logic [23:0] rem;
    logic [23:0] waddr;
    logic        ph;
    logic [7:0]  byte_q;
    logic [7:0]  lo;
    logic [31:0] tmo;
    logic [2:0]  si;
    logic        word_done;
    logic        buf_free;

    assign si        = sel[2:0];
    // A word closes on the odd byte of a pair or on the last byte of the entry.
    assign word_done = ph || rem == 24'd1;
    // The holding buffer can take a new word in the same cycle its old word is acknowledged.
    assign buf_free  = !RAM_WE || RAM_ACK;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            sel        <= 4'd0;
            rem        <= 24'd0;
            waddr      <= 24'd0;
            ph         <= 1'b0;
            byte_q     <= 8'd0;
            lo         <= 8'd0;
            tmo        <= 32'd0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            REGION_IDX <= 3'd0;
            FLASH_REQ  <= 1'b0;
            FLASH_ADDR <= 24'd0;
            RAM_WE     <= 1'b0;
            RAM_ADDR   <= 24'd0;
            RAM_DATA   <= 16'd0;
            RAM_BE     <= 2'b00;
        end else begin
            DONE <= 1'b0;
            if (RAM_WE && RAM_ACK)
                RAM_WE <= 1'b0;
            case (state)
                S_IDLE: if (START) begin
                    BUSY  <= 1'b1;
                    ERROR <= 1'b0;
                    sel   <= 4'd0;
                    state <= S_SEL;
                end
                S_SEL: if (sel == 4'(NUM_REGIONS)) begin
                    DONE       <= 1'b1;
                    BUSY       <= 1'b0;
                    REGION_IDX <= 3'd0;
                    state      <= S_FIN;
                end else if (EN[si] && SZ[si*24 +: 24] != 24'd0) begin
                    REGION_IDX <= si;
                    FLASH_ADDR <= FL[si*24 +: 24];
                    waddr      <= RM[si*24 +: 24];
                    rem        <= SZ[si*24 +: 24];
                    ph         <= 1'b0;
                    tmo        <= 32'd0;
                    FLASH_REQ  <= 1'b1;
                    state      <= S_RD;
                end else begin
                    sel <= sel + 4'd1;
                end
                S_RD: if (FLASH_ACK) begin
                    byte_q    <= FLASH_DATA;
                    FLASH_REQ <= 1'b0;
                    tmo       <= 32'd0;
                    state     <= S_PACK;
                end else if (tmo == 32'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: drop the request, discard any buffered word, finish with ERROR set.
                    FLASH_REQ  <= 1'b0;
                    RAM_WE     <= 1'b0;
                    ERROR      <= 1'b1;
                    tmo        <= 32'd0;
                    DONE       <= 1'b1;
                    BUSY       <= 1'b0;
                    REGION_IDX <= 3'd0;
                    state      <= S_FIN;
                end else begin
                    tmo <= tmo + 32'd1;
                end
                S_PACK: if (!word_done) begin
                    lo         <= byte_q;
                    ph         <= 1'b1;
                    rem        <= rem - 24'd1;
                    FLASH_ADDR <= FLASH_ADDR + 24'd1;
                    FLASH_REQ  <= 1'b1;
                    state      <= S_RD;
                end else if (buf_free) begin
                    RAM_WE     <= 1'b1;
                    RAM_ADDR   <= waddr;
                    RAM_DATA   <= ph ? {byte_q, lo} : {8'h00, byte_q};
                    RAM_BE     <= ph ? 2'b11 : 2'b01;
                    waddr      <= waddr + 24'd2;
                    ph         <= 1'b0;
                    rem        <= rem - 24'd1;
                    FLASH_ADDR <= FLASH_ADDR + 24'd1;
                    FLASH_REQ  <= rem != 24'd1;
                    state      <= rem == 24'd1 ? S_DRAIN : S_RD;
                end
                S_DRAIN: if (buf_free) begin
                    sel   <= sel + 4'd1;
                    state <= S_SEL;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_region_loader.sv
// tb_boot_region_loader: scoreboard bench for boot_region_loader with flash and SD-RAM responders.
module tb_boot_region_loader;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        BUSY, DONE, ERROR;
    logic [2:0]  REGION_IDX;
    logic        FLASH_REQ;
    logic [23:0] FLASH_ADDR;
    logic        FLASH_ACK = 1'b0;
    logic [7:0]  FLASH_DATA = 8'd0;
    logic        RAM_WE;
    logic [23:0] RAM_ADDR;
    logic [15:0] RAM_DATA;
    logic [1:0]  RAM_BE;
    logic        RAM_ACK = 1'b0;

    // Entry 2 disabled, entry 3 zero-sized, entry 4 wraps the flash address space.
    boot_region_loader #(
        .NUM_REGIONS   (5),
        .REGION_FLASH  ({24'hFF_FFFE, 24'h40_0000, 24'h30_0000, 24'h20_0000, 24'h10_0000}),
        .REGION_RAM    ({24'h73_0000, 24'h72_0000, 24'h7A_0000, 24'h71_0000, 24'h70_0000}),
        .REGION_SIZE   ({24'd4, 24'd0, 24'd5, 24'd3, 24'd4}),
        .REGION_EN     (5'b11011),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .REGION_IDX(REGION_IDX), .FLASH_REQ(FLASH_REQ), .FLASH_ADDR(FLASH_ADDR),
        .FLASH_ACK(FLASH_ACK), .FLASH_DATA(FLASH_DATA), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_DATA(RAM_DATA), .RAM_BE(RAM_BE), .RAM_ACK(RAM_ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {logic [23:0] addr; logic [2:0] idx;} fl_t;
    typedef struct packed {logic [23:0] addr; logic [15:0] data; logic [1:0] be;} wr_t;

    fl_t exp_fl[$];
    wr_t exp_wr[$];
    fl_t f;
    wr_t w;
    int  total = 0, bad = 0;
    bit  fl_en = 1'b1;
    int  ram_lat = 0;
    int  done_cnt = 0, req_cyc = 0, we_cyc = 0, wr_seen = 0, acks_we = 0, stall_max = 0, wwait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fmem(input logic [23:0] a);
        case (a)
            24'h10_0000: return 8'h11;
            24'h10_0001: return 8'h22;
            24'h10_0002: return 8'h33;
            24'h10_0003: return 8'h44;
            24'h20_0000: return 8'hAA;
            24'h20_0001: return 8'hBB;
            24'h20_0002: return 8'hCC;
            24'hFF_FFFE: return 8'h01;
            24'hFF_FFFF: return 8'h02;
            24'h00_0000: return 8'h03;
            24'h00_0001: return 8'h04;
            default:     return 8'hEE;
        endcase
    endfunction

    task automatic pf(input logic [23:0] a, input logic [2:0] i);
        exp_fl.push_back('{addr: a, idx: i});
    endtask

    task automatic pw(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
        exp_wr.push_back('{addr: a, data: d, be: be});
    endtask

    // Expected traffic for one complete pass over the table.
    task automatic push_full();
        pf(24'h10_0000, 3'd0); pf(24'h10_0001, 3'd0); pf(24'h10_0002, 3'd0); pf(24'h10_0003, 3'd0);
        pf(24'h20_0000, 3'd1); pf(24'h20_0001, 3'd1); pf(24'h20_0002, 3'd1);
        pf(24'hFF_FFFE, 3'd4); pf(24'hFF_FFFF, 3'd4); pf(24'h00_0000, 3'd4); pf(24'h00_0001, 3'd4);
        pw(24'h70_0000, 16'h2211, 2'b11); pw(24'h70_0002, 16'h4433, 2'b11);
        pw(24'h71_0000, 16'hBBAA, 2'b11); pw(24'h71_0002, 16'h00CC, 2'b01);
        pw(24'h73_0000, 16'h0201, 2'b11); pw(24'h73_0002, 16'h0403, 2'b11);
    endtask

    // Responders and monitor: everything sampled and driven on the falling edge.
    always @(negedge CLK) begin
        if (RESET) begin
            FLASH_ACK = 1'b0;
            RAM_ACK   = 1'b0;
            wwait     = 0;
            acks_we   = 0;
        end else begin
            if (DONE) begin
                done_cnt++;
                chk("done_busy_low", BUSY, 0);
            end
            if (FLASH_REQ) req_cyc++;
            if (RAM_WE) we_cyc++;
            if (RAM_ACK) RAM_ACK = 1'b0;
            else if (RAM_WE) begin
                if (wwait >= ram_lat) begin
                    if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                    else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", RAM_ADDR, w.addr);
                        chk("wr_data", RAM_DATA, w.data);
                        chk("wr_be", RAM_BE, w.be);
                    end
                    wr_seen++;
                    RAM_ACK = 1'b1;
                    wwait   = 0;
                    acks_we = 0;
                end else wwait++;
            end
            if (FLASH_ACK) FLASH_ACK = 1'b0;
            else if (FLASH_REQ && fl_en) begin
                if (exp_fl.size() == 0) chk("unexpected_flash_req", 1, 0);
                else begin
                    f = exp_fl.pop_front();
                    chk("flash_addr", FLASH_ADDR, f.addr);
                    chk("region_idx", REGION_IDX, f.idx);
                end
                FLASH_DATA = fmem(FLASH_ADDR);
                FLASH_ACK  = 1'b1;
                if (RAM_WE && !RAM_ACK) begin
                    acks_we++;
                    if (acks_we > stall_max) stall_max = acks_we;
                end
            end
        end
    end

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !DONE; i++) @(negedge CLK);
        chk("done_seen", DONE, 1);
    endtask

    task automatic full_run(input string tag);
        done_cnt = 0;
        push_full();
        pulse_start();
        chk({tag, "_busy"}, BUSY, 1);
        wait_done();
        chk({tag, "_error"}, ERROR, 0);
        repeat (3) @(negedge CLK);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
        chk({tag, "_fl_left"}, exp_fl.size(), 0);
        chk({tag, "_idle_idx"}, REGION_IDX, 0);
        chk({tag, "_idle_busy"}, BUSY, 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_idx", REGION_IDX, 0);
        chk("rst_req", FLASH_REQ, 0);
        chk("rst_we", RAM_WE, 0);

        full_run("basic");

        ram_lat   = 20;
        stall_max = 0;
        full_run("stall");
        chk("stall_fetch_ahead", stall_max, 2);
        ram_lat = 0;

        done_cnt = 0;
        push_full();
        pulse_start();
        repeat (8) @(negedge CLK);
        pulse_start();
        wait_done();
        repeat (3) @(negedge CLK);
        chk("busy_start_done_once", done_cnt, 1);
        chk("busy_start_wr_left", exp_wr.size(), 0);
        chk("busy_start_fl_left", exp_fl.size(), 0);

        fl_en    = 1'b0;
        req_cyc  = 0;
        we_cyc   = 0;
        done_cnt = 0;
        pulse_start();
        wait_done();
        chk("tmo_error", ERROR, 1);
        repeat (5) @(negedge CLK);
        chk("tmo_req_cycles", req_cyc, 16);
        chk("tmo_no_write", we_cyc, 0);
        chk("tmo_done_once", done_cnt, 1);
        chk("tmo_error_sticky", ERROR, 1);
        fl_en = 1'b1;

        push_full();
        pulse_start();
        chk("err_cleared", ERROR, 0);
        wait_done();
        repeat (3) @(negedge CLK);
        chk("after_tmo_wr_left", exp_wr.size(), 0);
        chk("after_tmo_fl_left", exp_fl.size(), 0);

        done_cnt = 0;
        wr_seen  = 0;
        push_full();
        pulse_start();
        for (int i = 0; i < 500 && wr_seen < 1; i++) @(negedge CLK);
        chk("abort_reached_entry", wr_seen >= 1, 1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_busy", BUSY, 0);
        chk("abort_req", FLASH_REQ, 0);
        chk("abort_addr", FLASH_ADDR, 0);
        chk("abort_we", RAM_WE, 0);
        chk("abort_idx", REGION_IDX, 0);
        chk("abort_done", DONE, 0);
        exp_fl.delete();
        exp_wr.delete();
        RESET   = 1'b0;
        req_cyc = 0;
        we_cyc  = 0;
        repeat (10) @(negedge CLK);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_req", req_cyc, 0);
        chk("abort_no_we", we_cyc, 0);

        full_run("recopy");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
